// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment scanner with per-frame input
// snapshot, per-digit blink and decimal point, and registered active-low outputs.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic [31:0] Disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  LE_in,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_done
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       idx;
  logic [FRM_W-1:0] frame_cnt;
  logic             blink_ph;
  logic [31:0]      disp_s;
  logic [7:0]       point_s;
  logic [7:0]       le_s;

  logic       tick_c;
  logic       wrap_c;
  logic       blank_c;
  logic [3:0] nib_c;
  logic [6:0] hex_c;
  logic [7:0] an_c;
  logic [7:0] seg_c;

  // Slot timing and next-output decode from the current scan state.
  always_comb begin
    tick_c  = EN && (div_cnt == DIV_W'(SCAN_DIV - 1));
    wrap_c  = tick_c && (idx == 3'd7);
    blank_c = !EN || (le_s[idx] && blink_ph);
    nib_c   = disp_s[{idx, 2'b00} +: 4];
    hex_c   = 7'h7F;
    case (nib_c)
      4'h0: hex_c = 7'h40;
      4'h1: hex_c = 7'h79;
      4'h2: hex_c = 7'h24;
      4'h3: hex_c = 7'h30;
      4'h4: hex_c = 7'h19;
      4'h5: hex_c = 7'h12;
      4'h6: hex_c = 7'h02;
      4'h7: hex_c = 7'h78;
      4'h8: hex_c = 7'h00;
      4'h9: hex_c = 7'h10;
      4'hA: hex_c = 7'h08;
      4'hB: hex_c = 7'h03;
      4'hC: hex_c = 7'h46;
      4'hD: hex_c = 7'h21;
      4'hE: hex_c = 7'h06;
      4'hF: hex_c = 7'h0E;
    endcase
    an_c  = blank_c ? 8'hFF : ~(8'h01 << idx);
    seg_c = blank_c ? 8'hFF : {~point_s[idx], hex_c};
  end

  // Divider, digit index, frame/blink counters and wrap-time snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      idx       <= 3'd0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
      disp_s    <= 32'd0;
      point_s   <= 8'd0;
      le_s      <= 8'd0;
    end else begin
      if (tick_c) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else if (EN) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (wrap_c) begin
        disp_s  <= Disp_num;
        point_s <= point_in;
        le_s    <= LE_in;
        if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end
    end
  end

  // Registered outputs keep anode switching glitch-free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AN         <= 8'hFF;
      SEGMENT    <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      AN         <= an_c;
      SEGMENT    <= seg_c;
      frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: a time-based reference model feeds
// a per-cycle expectation queue; scenario tasks pop it and add directed checks.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int unsigned SCAN_DIV     = 4;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned FRAME        = SCAN_DIV * 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic [31:0] Disp_num;
  logic [7:0]  point_in;
  logic [7:0]  LE_in;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_done;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)) dut (
    .clk(clk), .rst(rst), .EN(EN), .Disp_num(Disp_num), .point_in(point_in),
    .LE_in(LE_in), .AN(AN), .SEGMENT(SEGMENT), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return tab[v];
  endfunction

  // Reference model: position derived from the count of enabled cycles since reset.
  int unsigned m_t;
  logic [31:0] m_disp;
  logic [7:0]  m_pt, m_le;
  initial begin
    exp_t e;
    int unsigned m_idx, m_ph;
    logic blank;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_t = 0; m_disp = '0; m_pt = '0; m_le = '0;
        sb.delete();
      end else begin
        m_idx = (m_t / SCAN_DIV) % 8;
        m_ph  = ((m_t / FRAME) / BLINK_FRAMES) % 2;
        blank = !EN || (m_le[m_idx] && (m_ph == 1));
        e.an  = blank ? 8'hFF : ~(8'h01 << m_idx);
        e.seg = blank ? 8'hFF : {~m_pt[m_idx], hex7(m_disp[m_idx*4 +: 4])};
        e.fd  = EN && ((m_t % FRAME) == FRAME - 1);
        if (e.fd) begin
          m_disp = Disp_num; m_pt = point_in; m_le = LE_in;
        end
        if (EN) m_t++;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(output exp_t e);
    @(negedge clk);
    if (sb.size() > 0) e = sb.pop_front();
    else e = 'x;
  endtask

  task automatic wait_fd(output int n);
    exp_t e;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      step(e);
      if (frame_done === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic wait_an(input logic [7:0] target, output bit ok);
    exp_t e;
    ok = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      step(e);
      if (AN === target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b0; EN = 1'b0; Disp_num = '0; point_in = '0; LE_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1; EN = 1'b1; Disp_num = 32'hFFFF_FFFF; point_in = 8'hFF;
    repeat (40) step(e);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (AN !== 8'hFF || SEGMENT !== 8'hFF || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: AN=%h SEG=%h fd=%b, want FF FF 0", AN, SEGMENT, frame_done);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    step(e);
    vectors++;
    if (AN !== 8'hFE || SEGMENT !== 8'hC0) begin
      miscompares++;
      $display("FAIL reset_release: AN=%h SEG=%h, want FE C0", AN, SEGMENT);
    end
    vectors++;
    if ({AN, SEGMENT, frame_done} !== e) begin
      miscompares++;
      $display("FAIL reset_model: got %h, want %h", {AN, SEGMENT, frame_done}, e);
    end
    repeat (3) step(e);
    step(e);
    vectors++;
    if (AN !== 8'hFD) begin
      miscompares++;
      $display("FAIL reset_slot1: AN=%h, want FD", AN);
    end
  endtask

  task automatic test_digits();
    exp_t e;
    int n;
    Disp_num = 32'h1234_5678; point_in = 8'h01; LE_in = 8'h00;
    wait_fd(n);
    vectors++;
    if (n < 0) begin miscompares++; $display("FAIL digits_wrap: no frame_done, want pulse"); end
    step(e);
    vectors++;
    if (AN !== 8'hFE || SEGMENT !== 8'h00) begin
      miscompares++;
      $display("FAIL digits_d0: AN=%h SEG=%h, want FE 00", AN, SEGMENT);
    end
    repeat (27) step(e);
    step(e);
    vectors++;
    if (AN !== 8'h7F || SEGMENT !== 8'hF9) begin
      miscompares++;
      $display("FAIL digits_d7: AN=%h SEG=%h, want 7F F9", AN, SEGMENT);
    end
    wait_fd(n);
    vectors++;
    if (n != 3) begin miscompares++; $display("FAIL digits_fd_align: %0d cycles, want 3", n); end
    wait_fd(n);
    vectors++;
    if (n != 32) begin miscompares++; $display("FAIL digits_fd_period: %0d cycles, want 32", n); end
  endtask

  task automatic test_snapshot();
    logic [7:0] old_seg [4];
    logic [7:0] tgt;
    bit ok;
    int n;
    old_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    wait_an(8'hF7, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL snap_find_d3: AN never F7, want F7"); end
    Disp_num = 32'hFFFF_FFFF; point_in = 8'h00;
    for (int d = 4; d < 8; d++) begin
      tgt = ~(8'h01 << d);
      wait_an(tgt, ok);
      vectors++;
      if (!ok || SEGMENT !== old_seg[d-4]) begin
        miscompares++;
        $display("FAIL snap_old_d%0d: AN=%h SEG=%h, want %h %h", d, AN, SEGMENT, tgt, old_seg[d-4]);
      end
    end
    wait_fd(n);
    for (int d = 0; d < 8; d++) begin
      tgt = ~(8'h01 << d);
      wait_an(tgt, ok);
      vectors++;
      if (!ok || SEGMENT !== 8'h8E) begin
        miscompares++;
        $display("FAIL snap_new_d%0d: AN=%h SEG=%h, want %h 8E", d, AN, SEGMENT, tgt);
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    int n, lit_cnt;
    bit lit [8];
    LE_in = 8'h04;
    wait_fd(n);
    vectors++;
    if (n < 0) begin miscompares++; $display("FAIL blink_wrap: no frame_done, want pulse"); end
    for (int w = 0; w < 8; w++) begin
      lit[w] = 1'b0;
      for (int c = 0; c < 32; c++) begin
        step(e);
        vectors++;
        if ({AN, SEGMENT, frame_done} !== e) begin
          miscompares++;
          $display("FAIL blink_model f%0d c%0d: got %h, want %h", w, c, {AN, SEGMENT, frame_done}, e);
        end
        if (AN === 8'hFB) lit[w] = 1'b1;
      end
    end
    lit_cnt = 0;
    foreach (lit[w]) lit_cnt += int'(lit[w]);
    vectors++;
    if (lit_cnt != 4) begin
      miscompares++;
      $display("FAIL blink_count: digit2 lit in %0d of 8 frames, want 4", lit_cnt);
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (lit[k] == lit[k+2]) begin
        miscompares++;
        $display("FAIL blink_period f%0d: lit=%b and f%0d lit=%b, want opposite", k, lit[k], k+2, lit[k+2]);
      end
    end
  endtask

  task automatic test_enable();
    exp_t e;
    int n;
    bit ok;
    LE_in = 8'h00;
    wait_fd(n);
    wait_an(8'hF7, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL en_find_d3: AN never F7, want F7"); end
    step(e);
    EN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(e);
      vectors++;
      if (AN !== 8'hFF || SEGMENT !== 8'hFF || {AN, SEGMENT, frame_done} !== e) begin
        miscompares++;
        $display("FAIL en_off c%0d: AN=%h SEG=%h, want FF FF", i, AN, SEGMENT);
      end
    end
    EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(e);
      vectors++;
      if (AN !== ((i < 2) ? 8'hF7 : 8'hEF)) begin
        miscompares++;
        $display("FAIL en_resume c%0d: AN=%h, want %h", i, AN, (i < 2) ? 8'hF7 : 8'hEF);
      end
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [7:0] inv;
    for (int i = 0; i < 1000; i++) begin
      step(e);
      vectors++;
      if ({AN, SEGMENT, frame_done} !== e) begin
        miscompares++;
        $display("FAIL rand_model c%0d: got %h, want %h", i, {AN, SEGMENT, frame_done}, e);
      end
      inv = ~AN;
      vectors++;
      if ($isunknown(AN) || (AN !== 8'hFF && $countones(inv) != 1)) begin
        miscompares++;
        $display("FAIL rand_onehot c%0d: AN=%h, want FF or one-hot-low", i, AN);
      end
      EN = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) Disp_num = $urandom;
      if ($urandom_range(0, 31) == 0) point_in = 8'($urandom);
      if ($urandom_range(0, 31) == 0) LE_in = 8'($urandom);
    end
    EN = 1'b1;
  endtask

  initial begin
    test_reset();
    test_digits();
    test_snapshot();
    test_blink();
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
